// File: rtl/data_memory.sv
// rtl/data_memory.sv - 256-byte unified big-endian memory with a data port and an instruction port
//
// Ports:
//    clk    in   1   clock; writes happen on the rising edge
//    rst_n  in   1   asynchronous active-low reset; clears every byte
//    DI     in  32   write data
//    A      in   8   data-port byte address
//    Size   in   1   0 = byte access, 1 = word access
//    RW     in   1   0 = read, 1 = write
//    E      in   1   write enable, qualifies RW = 1
//    DO     out 32   data-port read data (combinational)
//    IA     in   8   instruction-port byte address
//    I      out 32   instruction-port read data (combinational, read-only)
module data_memory (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] DI,
   input  logic [7:0]  A,
   input  logic        Size,
   input  logic        RW,
   input  logic        E,
   output logic [31:0] DO,
   input  logic [7:0]  IA,
   output logic [31:0] I
);

   logic [7:0]  r_mem [0:255];

   logic [5:0]  w_dw;        // data-port word index (A[1:0] dropped)
   logic [5:0]  w_iw;        // instruction-port word index
   logic [31:0] w_dword;
   logic [31:0] w_iword;
   logic        w_we;

   assign w_dw = A[7:2];
   assign w_iw = IA[7:2];
   assign w_we = E & RW;

   // Big-endian assembly: lowest address lands in bits 31:24.
   assign w_dword = {r_mem[{w_dw, 2'b00}], r_mem[{w_dw, 2'b01}],
                     r_mem[{w_dw, 2'b10}], r_mem[{w_dw, 2'b11}]};
   assign w_iword = {r_mem[{w_iw, 2'b00}], r_mem[{w_iw, 2'b01}],
                     r_mem[{w_iw, 2'b10}], r_mem[{w_iw, 2'b11}]};

   // Outputs are forced to zero while reset is held so they read clean even
   // before the array has been cleared for the first time.
   assign DO = !rst_n ? 32'h0000_0000 :
               Size   ? w_dword : {24'h00_0000, r_mem[A]};
   assign I  = !rst_n ? 32'h0000_0000 : w_iword;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 256; k++) begin
            r_mem[k] <= 8'h00;
         end
      end else if (w_we) begin
         if (Size) begin
            r_mem[{w_dw, 2'b00}] <= DI[31:24];
            r_mem[{w_dw, 2'b01}] <= DI[23:16];
            r_mem[{w_dw, 2'b10}] <= DI[15:8];
            r_mem[{w_dw, 2'b11}] <= DI[7:0];
         end else begin
            r_mem[A] <= DI[7:0];
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - directed scoreboard bench for data_memory
module tb_data_memory;

   logic        clk;
   logic        rst_n;
   logic [31:0] DI;
   logic [7:0]  A;
   logic        Size;
   logic        RW;
   logic        E;
   logic [31:0] DO;
   logic [7:0]  IA;
   logic [31:0] I;

   int checks = 0;
   int errors = 0;

   logic [31:0] q_exp [$];
   logic [7:0]  mdl [0:255];

   data_memory dut (
      .clk  (clk),
      .rst_n(rst_n),
      .DI   (DI),
      .A    (A),
      .Size (Size),
      .RW   (RW),
      .E    (E),
      .DO   (DO),
      .IA   (IA),
      .I    (I)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mword(input logic [7:0] a);
      logic [7:0] b;
      b = {a[7:2], 2'b00};
      return {mdl[b], mdl[b + 8'd1], mdl[b + 8'd2], mdl[b + 8'd3]};
   endfunction

   function automatic logic [31:0] mread(input logic [7:0] a, input logic sz);
      if (!rst_n) return 32'h0;
      return sz ? mword(a) : {24'h0, mdl[a]};
   endfunction

   task automatic mclear();
      for (int k = 0; k < 256; k++) mdl[k] = 8'h00;
   endtask

   task automatic push(input logic [31:0] v);
      q_exp.push_back(v);
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      checks++;
      if (q_exp.size() == 0) begin
         errors++;
         $error("FAIL %s obs=%h exp=<empty scoreboard>", tag, obs);
      end else begin
         exp = q_exp.pop_front();
         assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
         end
      end
   endtask

   task automatic rd_do(input logic [7:0] a, input logic sz, input string tag);
      A = a; Size = sz;
      push(mread(a, sz));
      #1;
      cmp(tag, DO);
   endtask

   task automatic rd_i(input logic [7:0] ia, input string tag);
      IA = ia;
      push(rst_n ? mword(ia) : 32'h0);
      #1;
      cmp(tag, I);
   endtask

   // Drives one access for a full cycle; checks DO shows old data before the
   // edge and model data after it.
   task automatic wr(input logic [7:0] a, input logic sz, input logic [31:0] d,
                     input logic e, input logic rw, input string tag);
      logic [7:0] b;
      @(negedge clk);
      A = a; Size = sz; DI = d; E = e; RW = rw;
      push(mread(a, sz));
      #1;
      cmp({tag, "_pre"}, DO);
      @(posedge clk);
      if (e && rw && rst_n) begin
         if (sz) begin
            b = {a[7:2], 2'b00};
            mdl[b]        = d[31:24];
            mdl[b + 8'd1] = d[23:16];
            mdl[b + 8'd2] = d[15:8];
            mdl[b + 8'd3] = d[7:0];
         end else begin
            mdl[a] = d[7:0];
         end
      end
      #1;
      E = 1'b0; RW = 1'b0;
      push(mread(a, sz));
      #1;
      cmp({tag, "_post"}, DO);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      mclear();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; DI = 32'h0; A = 8'h0; Size = 1'b0; RW = 1'b0; E = 1'b0; IA = 8'h0;
      mclear();

      // Outputs held at zero during the very first reset.
      #3;
      push(32'h0); cmp("rst_do", DO);
      push(32'h0); cmp("rst_i", I);
      @(negedge clk);
      rst_n = 1'b1;

      // Whole array reads zero on both ports in both sizes.
      for (int k = 0; k < 256; k++) begin
         rd_do(k[7:0], 1'b0, "sweep_do_b");
         rd_do(k[7:0], 1'b1, "sweep_do_w");
         rd_i(k[7:0], "sweep_i");
      end

      // Word write and big-endian byte lanes.
      wr(8'd8, 1'b1, 32'hABCD_EF01, 1'b1, 1'b1, "w8");
      rd_do(8'd8, 1'b1, "w8_word");
      rd_do(8'd8, 1'b0, "w8_b0");
      rd_do(8'd9, 1'b0, "w8_b1");
      rd_do(8'd11, 1'b0, "w8_b3");
      rd_do(8'd10, 1'b1, "w8_unaligned");
      rd_i(8'd8, "w8_i");

      // Byte writes ignore DI[31:8].
      pulse_reset();
      rd_do(8'd8, 1'b1, "rst_clears_w8");
      wr(8'd0, 1'b0, 32'hFFFF_FFA6, 1'b1, 1'b1, "b0");
      wr(8'd2, 1'b0, 32'h0000_00DD, 1'b1, 1'b1, "b2");
      rd_do(8'd0, 1'b1, "b_word0");
      rd_do(8'd4, 1'b1, "b_word4");

      // Disabled accesses leave memory and DO untouched.
      wr(8'd8, 1'b1, 32'hABCD_EF01, 1'b1, 1'b1, "w8b");
      wr(8'd8, 1'b1, 32'h1122_3344, 1'b0, 1'b1, "e0");
      wr(8'd8, 1'b1, 32'h1122_3344, 1'b1, 1'b0, "rw0");
      wr(8'd9, 1'b0, 32'h0000_0077, 1'b0, 1'b1, "e0_byte");
      rd_do(8'd8, 1'b1, "w8_kept");

      // Instruction port sees a write to the word it is addressing.
      rd_i(8'h10, "ia10_pre");
      wr(8'h12, 1'b1, 32'h5A5A_C3C3, 1'b1, 1'b1, "w10");
      rd_i(8'h13, "ia10_post");

      // Top word of the array, no wrap to address 0.
      wr(8'hFE, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, "wfe");
      rd_do(8'hFC, 1'b0, "fc");
      rd_do(8'hFD, 1'b0, "fd");
      rd_do(8'hFE, 1'b0, "fe");
      rd_do(8'hFF, 1'b0, "ff");
      rd_do(8'hFD, 1'b1, "fd_word");
      rd_i(8'hFF, "iff");
      rd_do(8'h00, 1'b0, "mem0_kept");

      // Asynchronous reset between edges, then a blocked write under reset.
      @(negedge clk);
      A = 8'hFC; Size = 1'b1; IA = 8'h08;
      #1;
      push(mread(8'hFC, 1'b1)); cmp("pre_async_do", DO);
      push(mword(8'h08));       cmp("pre_async_i", I);
      rst_n = 1'b0;
      mclear();
      #1;
      push(32'h0); cmp("async_do", DO);
      push(32'h0); cmp("async_i", I);
      A = 8'h20; Size = 1'b1; DI = 32'h55AA_55AA; E = 1'b1; RW = 1'b1;
      @(posedge clk);
      #1;
      E = 1'b0; RW = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rd_do(8'h20, 1'b1, "blocked_w20");
      rd_do(8'hFC, 1'b1, "cleared_fc");
      rd_i(8'h08, "cleared_i8");
      wr(8'h20, 1'b1, 32'h1357_9BDF, 1'b1, 1'b1, "first_after_rst");
      rd_i(8'h20, "first_after_rst_i");

      if (q_exp.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_drain obs=%0d exp=0", q_exp.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have no parameters; storage is fixed at 256 bytes, 8-bit byte addresses.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port DI, input, 32 bits: write data.
REQ-005 The block SHALL have port A, input, 8 bits: data-port byte address.
REQ-006 The block SHALL have port Size, input, 1 bit: access size, 0 = byte, 1 = word (32 bits).
REQ-007 The block SHALL have port RW, input, 1 bit: 0 = read, 1 = write.
REQ-008 The block SHALL have port E, input, 1 bit: write enable, qualifying RW = 1.
REQ-009 The block SHALL have port DO, output, 32 bits: data-port read data.
REQ-010 The block SHALL have port IA, input, 8 bits: instruction-port byte address.
REQ-011 The block SHALL have port I, output, 32 bits: instruction-port read data (read-only port).

Function
REQ-012 The data port and the instruction port SHALL access one shared 256-byte array (unified memory).
REQ-013 Byte order SHALL be big-endian: the word at aligned address W is {mem[W], mem[W+1], mem[W+2], mem[W+3]}, with mem[W] in bits 31:24.
REQ-014 Word accesses SHALL ignore A[1:0]; W = {A[7:2], 2'b00}. There is no misalignment error and no wrap past 0xFF.
REQ-015 DO SHALL be combinational and always driven, regardless of RW and E.
REQ-016 With Size = 1, DO SHALL equal the word at W.
REQ-017 With Size = 0, DO SHALL equal {24'h0, mem[A]}.
REQ-018 I SHALL be combinational: the word at {IA[7:2], 2'b00}, in the same byte order as REQ-013.
REQ-019 A write SHALL occur on a rising clk edge only when rst_n = 1, E = 1 and RW = 1.
REQ-020 A byte write (Size = 0) SHALL store DI[7:0] to mem[A]; all other bytes are unchanged, and DI[31:8] is ignored.
REQ-021 A word write (Size = 1) SHALL store DI[31:24], DI[23:16], DI[15:8], DI[7:0] to mem[W..W+3] respectively.
REQ-022 E = 0, or RW = 0, SHALL leave the memory unchanged regardless of the other inputs.
REQ-023 DO and I SHALL show the pre-write contents until the write edge and the new contents immediately after it (no write-through bypass).
REQ-024 A write SHALL be visible on both ports after the edge, including when IA addresses the written word.
REQ-025 Write latency SHALL be 1 edge; read latency SHALL be 0 cycles (combinational).

Reset
REQ-026 rst_n = 0 SHALL asynchronously clear all 256 bytes to 0x00, without waiting for a clk edge.
REQ-027 While rst_n = 0, DO and I SHALL read 32'h00000000, and writes SHALL be blocked.
REQ-028 Reset asserted mid-operation SHALL discard any pending write; the first write is accepted on the first rising edge after rst_n returns to 1.
REQ-029 Memory contents SHALL be undefined before the first reset; the bench SHALL reset first.

Verification
REQ-030 Reset, then sweep A and IA over 0..255 in both Size modes -> DO = 0 and I = 0 everywhere.
REQ-031 Word write 0xABCDEF01 at A = 8 -> word read at A = 8 gives ABCDEF01; byte reads at A = 8 and A = 11 give 000000AB and 00000001; IA = 8 gives ABCDEF01.
REQ-032 After reset, byte write 0xA6 at A = 0, then byte write 0x000000DD at A = 2 -> word read at A = 0 gives A600DD00; word read at A = 4 gives 00000000.
REQ-033 Write 0x11223344 at A = 8 with E = 0/RW = 1, then with E = 1/RW = 0 -> word at 8 unchanged in both cases; DO never changes during either attempt.
REQ-034 Word write 0xCAFEF00D at A = 0xFE -> bytes 0xFC..0xFF hold CA FE F0 0D; word reads at A = 0xFD and at IA = 0xFF give CAFEF00D; mem[0x00] is unchanged.
REQ-035 After nonzero writes, drive rst_n low between clk edges -> DO and I go to 0 within the same time step; a write presented with rst_n low is not stored.
